// File: rtl/score_keeper.sv
// Game-state tracker for the two-player memory game: scores, pairs found, turn owner and per-turn countdown.
// Latency: one cycle from start/pick_valid to every registered output; timeout is a single-cycle pulse.
// Backpressure: none; every pick_valid pulse is consumed, including back-to-back ones.
module score_keeper #(
    parameter int PAIRS     = 8,
    parameter int TURN_SECS = 15,
    parameter int CLK_HZ    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pick_valid,
    input  logic       pick_match,
    output logic [3:0] player1,
    output logic [3:0] player2,
    output logic [3:0] parejas,
    output logic       turn,
    output logic [3:0] time_left,
    output logic       timeout,
    output logic       game_over
);

    localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PS_MAX    = PW'(CLK_HZ - 1);
    localparam logic [3:0]      SECS      = 4'(TURN_SECS);
    localparam logic [3:0]      LAST_PAIR = 4'(PAIRS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;

    // Single FSM: start overrides everything, a pick overrides the timer, the timer runs otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            player1   <= 4'd0;
            player2   <= 4'd0;
            parejas   <= 4'd0;
            turn      <= 1'b0;
            time_left <= 4'd0;
            prescaler <= '0;
            timeout   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (start) begin
                state     <= PLAY;
                player1   <= 4'd0;
                player2   <= 4'd0;
                parejas   <= 4'd0;
                turn      <= 1'b0;
                time_left <= SECS;
                prescaler <= '0;
                game_over <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (pick_valid) begin
                            // Any completed comparison restarts the turn clock.
                            time_left <= SECS;
                            prescaler <= '0;
                            if (pick_match) begin
                                if (turn) player2 <= player2 + 4'd1;
                                else      player1 <= player1 + 4'd1;
                                parejas <= parejas + 4'd1;
                                if (parejas == LAST_PAIR) begin
                                    state     <= DONE;
                                    game_over <= 1'b1;
                                end
                            end else begin
                                turn <= ~turn;
                            end
                        end else if (prescaler == PS_MAX) begin
                            prescaler <= '0;
                            if (time_left == 4'd1) begin
                                // Expiry hands the move over without ever showing zero.
                                turn      <= ~turn;
                                time_left <= SECS;
                                timeout   <= 1'b1;
                            end else begin
                                time_left <= time_left - 4'd1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                    DONE:    state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
